// File: rtl/fc_neuron_core_pkg.sv
// Shared types and default sizing for the fully-connected neuron datapath.
package fc_neuron_core_pkg;

    localparam int unsigned FC_LANES   = 8;
    localparam int unsigned FC_DW      = 8;
    localparam int unsigned FC_ACC_W   = 32;
    localparam int unsigned FC_OUT_W   = 8;
    localparam int unsigned FC_CNT_W   = 10;
    localparam int unsigned FC_SHIFT_W = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        FLUSH = 2'd2,
        HOLD  = 2'd3
    } fc_state_t;

    // Sideband carried alongside each beat through the product/sum pipeline.
    typedef struct packed {
        logic first;
        logic last;
    } fc_tag_t;

endpackage

// File: rtl/fc_neuron_core_if.sv
// Beat input stream and result output stream of the neuron core.
interface fc_neuron_core_if
    import fc_neuron_core_pkg::*;
#(
    parameter int unsigned LANES = FC_LANES,
    parameter int unsigned DW    = FC_DW,
    parameter int unsigned ACC_W = FC_ACC_W,
    parameter int unsigned OUT_W = FC_OUT_W
);

    logic                  in_valid;
    logic                  in_ready;
    logic [LANES*DW-1:0]   in_data;
    logic [LANES*DW-1:0]   in_weight;

    logic                  out_valid;
    logic                  out_ready;
    logic [OUT_W-1:0]      out_data;
    logic [ACC_W-1:0]      out_acc;
    logic                  out_sat;

    modport master (
        output in_valid, in_data, in_weight, out_ready,
        input  in_ready, out_valid, out_data, out_acc, out_sat
    );

    modport slave (
        input  in_valid, in_data, in_weight, out_ready,
        output in_ready, out_valid, out_data, out_acc, out_sat
    );

endinterface

// File: rtl/fc_neuron_core_dot_lanes.sv
// Per-beat dot product: S1 lane multipliers, S2 adder tree, each with a valid bit.
module fc_neuron_core_dot_lanes
    import fc_neuron_core_pkg::*;
#(
    parameter int unsigned LANES = FC_LANES,
    parameter int unsigned DW    = FC_DW,
    parameter int unsigned ACC_W = FC_ACC_W
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    in_valid,
    input  fc_tag_t                 in_tag,
    input  logic [LANES*DW-1:0]     in_data,
    input  logic [LANES*DW-1:0]     in_weight,
    output logic                    out_valid,
    output fc_tag_t                 out_tag,
    output logic signed [ACC_W-1:0] out_sum
);

    localparam int unsigned PW = 2 * DW + 1;

    logic signed [PW-1:0]    prod_d [LANES];
    logic signed [PW-1:0]    prod_q [LANES];
    logic                    s1_valid_d, s1_valid_q;
    fc_tag_t                 s1_tag_d, s1_tag_q;
    logic signed [ACC_W-1:0] sum_d, sum_q;
    logic                    s2_valid_d, s2_valid_q;
    fc_tag_t                 s2_tag_d, s2_tag_q;

    // S1: unsigned data (zero-extended) times signed weight, one product per lane.
    always_comb begin : s1_mult
        logic [PW-1:0] d_ext;
        logic [PW-1:0] w_ext;
        s1_valid_d = in_valid;
        s1_tag_d   = in_valid ? in_tag : s1_tag_q;
        for (int i = 0; i < int'(LANES); i++) begin
            d_ext     = PW'(in_data[i*DW +: DW]);
            w_ext     = PW'($signed(in_weight[i*DW +: DW]));
            prod_d[i] = in_valid ? ($signed(d_ext) * $signed(w_ext)) : prod_q[i];
        end
    end

    // S2: heap-ordered binary tree; leaves sit at LANES-1 .. 2*LANES-2.
    always_comb begin : s2_tree
        logic signed [ACC_W-1:0] node [2*LANES-1];
        for (int i = 0; i < int'(LANES); i++) begin
            node[int'(LANES) - 1 + i] = ACC_W'(prod_q[i]);
        end
        for (int i = int'(LANES) - 2; i >= 0; i--) begin
            node[i] = node[2*i+1] + node[2*i+2];
        end
        s2_valid_d = s1_valid_q;
        s2_tag_d   = s1_valid_q ? s1_tag_q : s2_tag_q;
        sum_d      = s1_valid_q ? node[0] : sum_q;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_valid_q <= 1'b0;
            s1_tag_q   <= '0;
            for (int i = 0; i < int'(LANES); i++) begin
                prod_q[i] <= '0;
            end
            s2_valid_q <= 1'b0;
            s2_tag_q   <= '0;
            sum_q      <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_tag_q   <= s1_tag_d;
            for (int i = 0; i < int'(LANES); i++) begin
                prod_q[i] <= prod_d[i];
            end
            s2_valid_q <= s2_valid_d;
            s2_tag_q   <= s2_tag_d;
            sum_q      <= sum_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign out_tag   = s2_tag_q;
    assign out_sum   = sum_q;

endmodule

// File: rtl/fc_neuron_core.sv
// Fully-connected neuron engine: beat FSM, accumulator and requantiser around the lane dot product.
module fc_neuron_core
    import fc_neuron_core_pkg::*;
#(
    parameter int unsigned LANES = FC_LANES,
    parameter int unsigned DW    = FC_DW,
    parameter int unsigned ACC_W = FC_ACC_W,
    parameter int unsigned OUT_W = FC_OUT_W,
    parameter int unsigned CNT_W = FC_CNT_W
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [CNT_W-1:0]      cfg_beats,
    input  logic [FC_SHIFT_W-1:0] cfg_shift,
    input  logic                  cfg_relu,
    input  logic [ACC_W-1:0]      bias,
    fc_neuron_core_if.slave       bus,
    output logic                  busy
);

    localparam logic signed [ACC_W:0] SAT_MAX = (ACC_W+1)'((2 ** (OUT_W - 1)) - 1);
    localparam logic signed [ACC_W:0] SAT_MIN = ~SAT_MAX;

    fc_state_t               state_d, state_q;
    logic [CNT_W-1:0]        beat_cnt_d, beat_cnt_q;
    logic [CNT_W-1:0]        beats_d, beats_q;
    logic [FC_SHIFT_W-1:0]   shift_d, shift_q;
    logic                    relu_d, relu_q;
    logic signed [ACC_W-1:0] bias_d, bias_q;
    logic                    in_ready_d, in_ready_q;
    logic                    busy_d, busy_q;

    logic signed [ACC_W-1:0] acc_d, acc_q;
    logic                    s3_valid_d, s3_valid_q;
    logic                    s3_last_d, s3_last_q;

    logic                    out_valid_d, out_valid_q;
    logic [OUT_W-1:0]        out_data_d, out_data_q;
    logic [ACC_W-1:0]        out_acc_d, out_acc_q;
    logic                    out_sat_d, out_sat_q;

    logic                    in_fire, res_fire, out_fire, beat_last;
    logic [CNT_W-1:0]        beats_eff;
    fc_tag_t                 beat_tag;
    logic                    dot_valid;
    fc_tag_t                 dot_tag;
    logic signed [ACC_W-1:0] dot_sum;

    logic signed [ACC_W-1:0] r_val;
    logic signed [ACC_W:0]   r_ext, rnd, q_ext, q_clip;
    logic                    q_sat;

    assign in_fire   = bus.in_valid & in_ready_q;
    assign res_fire  = s3_valid_q & s3_last_q;
    assign out_fire  = out_valid_q & bus.out_ready;
    assign beats_eff = (cfg_beats == '0) ? CNT_W'(1) : cfg_beats;
    assign beat_last = (state_q == IDLE) ? (beats_eff == CNT_W'(1))
                                         : (beat_cnt_q == beats_q - CNT_W'(1));
    assign beat_tag  = '{first: (state_q == IDLE), last: beat_last};

    fc_neuron_core_dot_lanes #(
        .LANES (LANES),
        .DW    (DW),
        .ACC_W (ACC_W)
    ) u_dot (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (in_fire),
        .in_tag    (beat_tag),
        .in_data   (bus.in_data),
        .in_weight (bus.in_weight),
        .out_valid (dot_valid),
        .out_tag   (dot_tag),
        .out_sum   (dot_sum)
    );

    // Neuron sequencing; configuration is captured with the first beat only.
    always_comb begin : fsm_next
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        beats_d    = beats_q;
        shift_d    = shift_q;
        relu_d     = relu_q;
        bias_d     = bias_q;
        case (state_q)
            IDLE: begin
                if (in_fire) begin
                    beats_d    = beats_eff;
                    shift_d    = cfg_shift;
                    relu_d     = cfg_relu;
                    bias_d     = $signed(bias);
                    beat_cnt_d = CNT_W'(1);
                    state_d    = beat_last ? FLUSH : ACCUM;
                end
            end
            ACCUM: begin
                if (in_fire) begin
                    beat_cnt_d = beat_cnt_q + CNT_W'(1);
                    if (beat_last) begin
                        beat_cnt_d = '0;
                        state_d    = FLUSH;
                    end
                end
            end
            FLUSH: begin
                if (res_fire) state_d = HOLD;
            end
            HOLD: begin
                if (out_fire) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        in_ready_d = (state_d == IDLE) || (state_d == ACCUM);
        busy_d     = (state_d != IDLE);
    end

    // S3: the first beat of a neuron restarts the running sum.
    always_comb begin : accum_next
        s3_valid_d = dot_valid;
        s3_last_d  = dot_valid ? dot_tag.last : s3_last_q;
        acc_d      = acc_q;
        if (dot_valid) begin
            acc_d = dot_tag.first ? dot_sum : (acc_q + dot_sum);
        end
    end

    // Rounding shift is done one bit wider so the half-LSB add cannot overflow.
    always_comb begin : requant
        r_val = bias_q + acc_q;
        r_ext = (ACC_W+1)'(r_val);
        rnd   = (shift_q == '0) ? '0 : ((ACC_W+1)'(1) << (shift_q - FC_SHIFT_W'(1)));
        q_ext = (r_ext + rnd) >>> shift_q;
        q_sat = 1'b0;
        if (relu_q && q_ext[ACC_W]) begin
            q_clip = '0;
        end else if (q_ext > SAT_MAX) begin
            q_clip = SAT_MAX;
            q_sat  = 1'b1;
        end else if (q_ext < SAT_MIN) begin
            q_clip = SAT_MIN;
            q_sat  = 1'b1;
        end else begin
            q_clip = q_ext;
        end
    end

    // S4: result register, held until the downstream handshake.
    always_comb begin : result_next
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_acc_d   = out_acc_q;
        out_sat_d   = out_sat_q;
        if (res_fire) begin
            out_valid_d = 1'b1;
            out_data_d  = OUT_W'(q_clip);
            out_acc_d   = r_val;
            out_sat_d   = q_sat;
        end else if (out_fire) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            beat_cnt_q  <= '0;
            beats_q     <= '0;
            shift_q     <= '0;
            relu_q      <= 1'b0;
            bias_q      <= '0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            acc_q       <= '0;
            s3_valid_q  <= 1'b0;
            s3_last_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_acc_q   <= '0;
            out_sat_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_cnt_q  <= beat_cnt_d;
            beats_q     <= beats_d;
            shift_q     <= shift_d;
            relu_q      <= relu_d;
            bias_q      <= bias_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
            acc_q       <= acc_d;
            s3_valid_q  <= s3_valid_d;
            s3_last_q   <= s3_last_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_acc_q   <= out_acc_d;
            out_sat_q   <= out_sat_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_acc   = out_acc_q;
    assign bus.out_sat   = out_sat_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_fc_neuron_core.sv
// Bench for fc_neuron_core: directed table, reset/backpressure sequences, randomized neurons vs an arithmetic model.
module tb_fc_neuron_core;
    import fc_neuron_core_pkg::*;

    localparam int unsigned LANES = 8;
    localparam int unsigned DW    = 8;
    localparam int unsigned ACC_W = 32;
    localparam int unsigned OUT_W = 8;
    localparam int unsigned CNT_W = 10;

    logic             clk = 1'b0;
    logic             rstn = 1'b0;
    logic [CNT_W-1:0] cfg_beats;
    logic [4:0]       cfg_shift;
    logic             cfg_relu;
    logic [ACC_W-1:0] bias;
    logic             busy;

    fc_neuron_core_if #(.LANES(LANES), .DW(DW), .ACC_W(ACC_W), .OUT_W(OUT_W)) bus ();

    fc_neuron_core #(
        .LANES(LANES), .DW(DW), .ACC_W(ACC_W), .OUT_W(OUT_W), .CNT_W(CNT_W)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .cfg_beats (cfg_beats),
        .cfg_shift (cfg_shift),
        .cfg_relu  (cfg_relu),
        .bias      (bias),
        .bus       (bus),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [LANES*DW-1:0] qd [$];
    logic [LANES*DW-1:0] qw [$];

    typedef struct {
        int beats; int shift; bit relu; int bias_v; int d; int w;
        int e_acc; int e_q; bit e_sat;
    } vec_t;

    task automatic check(input string name, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic fill_uniform(input int n, input int d, input int w);
        logic [DW-1:0] dd, ww;
        dd = DW'(d);
        ww = DW'(w);
        qd.delete();
        qw.delete();
        for (int b = 0; b < n; b++) begin
            qd.push_back({LANES{dd}});
            qw.push_back({LANES{ww}});
        end
    endtask

    task automatic fill_random(input int n);
        qd.delete();
        qw.delete();
        for (int b = 0; b < n; b++) begin
            qd.push_back({$urandom, $urandom});
            qw.push_back({$urandom, $urandom});
        end
    endtask

    // Reference: exact dot product, wrap to ACC_W, exact rounding shift, relu, clamp.
    function automatic void model(input int shift, input bit relu, input int bias_v,
                                  output int e_acc, output int e_q, output bit e_sat);
        longint s = 0;
        longint q, lim;
        for (int b = 0; b < qd.size(); b++) begin
            for (int l = 0; l < int'(LANES); l++) begin
                logic [DW-1:0]        dv;
                logic signed [DW-1:0] wv;
                dv = qd[b][l*DW +: DW];
                wv = qw[b][l*DW +: DW];
                s += longint'(dv) * longint'(wv);
            end
        end
        e_acc = int'(longint'(bias_v) + s);
        q = longint'(e_acc);
        if (shift > 0) q = (q + (longint'(1) <<< (shift - 1))) >>> shift;
        if (relu && q < 0) q = 0;
        lim = longint'(1) <<< (OUT_W - 1);
        e_sat = 1'b0;
        if (q > lim - 1) begin q = lim - 1; e_sat = 1'b1; end
        else if (q < -lim) begin q = -lim; e_sat = 1'b1; end
        e_q = int'(q);
    endfunction

    task automatic run_neuron(input string nm, input int beats_cfg, input int shift, input bit relu,
                              input int bias_v, input int gap_pct, input int hold_cycles,
                              output int r_acc, output int r_q, output bit r_sat);
        int e_acc, e_q, idx, wd, lat;
        bit e_sat, fire, first, v;
        model(shift, relu, bias_v, e_acc, e_q, e_sat);
        cfg_beats = CNT_W'(beats_cfg);
        cfg_shift = 5'(shift);
        cfg_relu  = relu;
        bias      = ACC_W'(bias_v);
        bus.out_ready = 1'b0;
        idx = 0; wd = 0; first = 1'b1;
        while (idx < qd.size() && wd < 8000) begin
            v = ($urandom_range(99) >= gap_pct);
            bus.in_valid  = v;
            bus.in_data   = qd[idx];
            bus.in_weight = qw[idx];
            fire = v && bus.in_ready;
            @(posedge clk); #1;
            wd++;
            if (fire) begin
                idx++;
                if (first) begin
                    // later cfg changes must not affect the running neuron
                    cfg_beats = CNT_W'($urandom);
                    cfg_shift = 5'($urandom);
                    cfg_relu  = 1'($urandom);
                    bias      = $urandom;
                    first = 1'b0;
                end
            end
        end
        bus.in_valid = 1'b0;
        check({nm, " beats accepted"}, idx, qd.size());
        lat = 0;
        while (!bus.out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check({nm, " latency"}, lat, 3);
        for (int c = 0; c < hold_cycles; c++) begin
            bus.in_valid  = 1'b1;
            bus.in_data   = {$urandom, $urandom};
            bus.in_weight = {$urandom, $urandom};
            @(posedge clk); #1;
            check({nm, " hold out_valid"}, bus.out_valid, 1);
            check({nm, " hold in_ready"}, bus.in_ready, 0);
            check({nm, " hold out_acc"}, int'($signed(bus.out_acc)), e_acc);
            check({nm, " hold out_data"}, int'($signed(bus.out_data)), e_q);
            check({nm, " hold out_sat"}, bus.out_sat, e_sat);
        end
        bus.in_valid = 1'b0;
        r_acc = int'($signed(bus.out_acc));
        r_q   = int'($signed(bus.out_data));
        r_sat = bus.out_sat;
        check({nm, " out_acc"}, r_acc, e_acc);
        check({nm, " out_data"}, r_q, e_q);
        check({nm, " out_sat"}, r_sat, e_sat);
        check({nm, " busy in hold"}, busy, 1);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check({nm, " out_valid after handshake"}, bus.out_valid, 0);
        check({nm, " in_ready after handshake"}, bus.in_ready, 1);
        check({nm, " busy after handshake"}, busy, 0);
    endtask

    vec_t tbl [15];

    initial begin
        int r_acc, r_q, nb, cb;
        bit r_sat;

        tbl[0]  = '{1,    0, 1'b0, 10,          1,   2,    26,          26,   1'b0};
        tbl[1]  = '{64,   8, 1'b0, 0,           255, -128, -16711680,   -128, 1'b1};
        tbl[2]  = '{64,   8, 1'b1, 0,           255, -128, -16711680,   0,    1'b0};
        tbl[3]  = '{1,    2, 1'b0, 6,           0,   0,    6,           2,    1'b0};
        tbl[4]  = '{1,    2, 1'b0, -6,          0,   0,    -6,          -1,   1'b0};
        tbl[5]  = '{1,    0, 1'b0, 300,         0,   0,    300,         127,  1'b1};
        tbl[6]  = '{0,    0, 1'b0, 0,           1,   1,    8,           8,    1'b0};
        tbl[7]  = '{2,    1, 1'b0, 50,          3,   -1,   2,           1,    1'b0};
        tbl[8]  = '{1,    0, 1'b0, -200,        0,   0,    -200,        -128, 1'b1};
        tbl[9]  = '{3,    4, 1'b0, -1000,       10,  5,    200,         13,   1'b0};
        tbl[10] = '{1,    0, 1'b1, -5,          0,   0,    -5,          0,    1'b0};
        tbl[11] = '{1,   31, 1'b0, 2147483647,  1,   1,    -2147483641, -1,   1'b0};
        tbl[12] = '{1,   31, 1'b0, 2147483647,  0,   0,    2147483647,  1,    1'b0};
        tbl[13] = '{1,    0, 1'b0, -2147483647 - 1, 0, 0,  -2147483647 - 1, -128, 1'b1};
        tbl[14] = '{1023, 7, 1'b0, 0,           1,   1,    8184,        64,   1'b0};

        cfg_beats = '0; cfg_shift = '0; cfg_relu = 1'b0; bias = '0;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.in_weight = '0; bus.out_ready = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("reset in_ready", bus.in_ready, 1);
        check("reset out_valid", bus.out_valid, 0);
        check("reset busy", busy, 0);
        check("reset out_data", bus.out_data, 0);
        check("reset out_acc", bus.out_acc, 0);
        check("reset out_sat", bus.out_sat, 0);
        rstn = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 15; i++) begin
            string nm;
            nm = $sformatf("row%0d", i);
            fill_uniform((tbl[i].beats == 0) ? 1 : tbl[i].beats, tbl[i].d, tbl[i].w);
            run_neuron(nm, tbl[i].beats, tbl[i].shift, tbl[i].relu, tbl[i].bias_v, 0, 0,
                       r_acc, r_q, r_sat);
            check({nm, " table acc"}, r_acc, tbl[i].e_acc);
            check({nm, " table data"}, r_q, tbl[i].e_q);
            check({nm, " table sat"}, r_sat, tbl[i].e_sat);
        end

        // Reset in the middle of a neuron discards its partial sum.
        fill_uniform(10, 5, 7);
        cfg_beats = 10; cfg_shift = '0; cfg_relu = 1'b0; bias = '0;
        bus.in_valid = 1'b1; bus.in_data = qd[0]; bus.in_weight = qw[0];
        repeat (4) begin @(posedge clk); #1; end
        check("midrst busy before", busy, 1);
        rstn = 1'b0;
        #1;
        bus.in_valid = 1'b0;
        check("midrst in_ready", bus.in_ready, 1);
        check("midrst out_valid", bus.out_valid, 0);
        check("midrst busy", busy, 0);
        @(posedge clk); #1;
        rstn = 1'b1;
        repeat (6) begin @(posedge clk); #1; end
        check("midrst out_valid idle", bus.out_valid, 0);
        fill_uniform(3, 1, 1);
        run_neuron("post-reset", 3, 0, 1'b0, 0, 0, 0, r_acc, r_q, r_sat);
        check("post-reset fresh acc", r_acc, 24);

        // Backpressure for 5 cycles with ignored beats, then a following neuron.
        fill_random(5);
        run_neuron("backpressure", 5, 6, 1'b0, int'($urandom), 0, 5, r_acc, r_q, r_sat);
        fill_uniform(2, 2, 3);
        run_neuron("after-bp", 2, 0, 1'b0, 1, 0, 0, r_acc, r_q, r_sat);
        check("after-bp acc", r_acc, 97);

        // Same 16 beats back-to-back and with random in_valid gaps.
        fill_random(16);
        run_neuron("gap0", 16, 9, 1'b0, 12345, 0, 0, r_acc, r_q, r_sat);
        run_neuron("gap50", 16, 9, 1'b0, 12345, 50, 0, r_acc, r_q, r_sat);

        // Randomized neurons.
        for (int n = 0; n < 25; n++) begin
            nb = int'($urandom_range(1, 12));
            cb = (nb == 1 && $urandom_range(1) == 1) ? 0 : nb;
            fill_random(nb);
            run_neuron($sformatf("rand%0d", n), cb, int'($urandom_range(0, 20)),
                       1'($urandom), int'($urandom), int'($urandom_range(0, 40)),
                       int'($urandom_range(0, 2)), r_acc, r_q, r_sat);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
